// File: rtl/uart_buffered_echo.sv
`default_nettype none
// ============================================================================
// Module   : uart_buffered_echo
// Purpose  : FIFO-buffered RX->TX echo with per-byte transform and TX sequencer.
// Revision : 1.0  initial release
// ============================================================================
module uart_buffered_echo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int TX_TIMEOUT = 4096
) (
    input  logic                        i_Clk,
    input  logic                        i_Reset,
    input  logic                        i_RX_DV,
    input  logic [DATA_WIDTH-1:0]       i_RX_Byte,
    input  logic [1:0]                  i_Mode,
    input  logic                        i_TX_Active,
    input  logic                        i_TX_Done,
    input  logic                        i_Clear_Err,
    output logic                        o_TX_DV,
    output logic [DATA_WIDTH-1:0]       o_TX_Byte,
    output logic [DATA_WIDTH-1:0]       o_Display_Byte,
    output logic [$clog2(DEPTH):0]      o_Count,
    output logic                        o_Empty,
    output logic                        o_Full,
    output logic                        o_Overflow,
    output logic                        o_TX_Error
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_TW = $clog2(TX_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DONE = 2'd1,
        S_GAP       = 2'd2
    } state_t;

    state_t                 r_state;
    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic [c_AW-1:0]        r_wptr;
    logic [c_AW-1:0]        r_rptr;
    logic [c_TW-1:0]        r_tmo;

    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic [DATA_WIDTH-1:0]  w_data;
    logic [c_CW-1:0]        w_count_nxt;

    // Case folding only looks at the low byte so wider paths keep their upper bits.
    function automatic logic [DATA_WIDTH-1:0] f_transform(
        input logic [DATA_WIDTH-1:0] b,
        input logic [1:0]            m
    );
        logic [DATA_WIDTH-1:0] t;
        t = b;
        case (m)
            2'b01: if (b[7:0] >= 8'h61 && b[7:0] <= 8'h7A) t[7:0] = b[7:0] - 8'h20;
            2'b10: if (b[7:0] >= 8'h41 && b[7:0] <= 8'h5A) t[7:0] = b[7:0] + 8'h20;
            2'b11: t = ~b;
            default: t = b;
        endcase
        return t;
    endfunction

    always_comb begin
        w_pop  = (r_state == S_IDLE) && !o_Empty && !i_TX_Active;
        w_push = i_RX_DV && (!o_Full || w_pop);
        w_drop = i_RX_DV && o_Full && !w_pop;
        w_data = f_transform(i_RX_Byte, i_Mode);
        w_count_nxt = o_Count;
        if (w_push && !w_pop)
            w_count_nxt = o_Count + c_CW'(1);
        else if (!w_push && w_pop)
            w_count_nxt = o_Count - c_CW'(1);
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge i_Clk) begin
        if (w_push)
            r_mem[r_wptr] <= w_data;
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            r_state        <= S_IDLE;
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_tmo          <= '0;
            o_Count        <= '0;
            o_Empty        <= 1'b1;
            o_Full         <= 1'b0;
            o_TX_DV        <= 1'b0;
            o_TX_Byte      <= '0;
            o_Display_Byte <= '0;
            o_Overflow     <= 1'b0;
            o_TX_Error     <= 1'b0;
        end else begin
            o_TX_DV <= 1'b0;

            if (i_RX_DV)
                o_Display_Byte <= i_RX_Byte;
            if (w_push)
                r_wptr <= r_wptr + c_AW'(1);

            o_Count <= w_count_nxt;
            o_Empty <= (w_count_nxt == '0);
            o_Full  <= (w_count_nxt == c_CW'(DEPTH));

            if (w_drop)
                o_Overflow <= 1'b1;
            else if (i_Clear_Err)
                o_Overflow <= 1'b0;

            if (i_Clear_Err)
                o_TX_Error <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        o_TX_Byte <= r_mem[r_rptr];
                        o_TX_DV   <= 1'b1;
                        r_rptr    <= r_rptr + c_AW'(1);
                        r_tmo     <= '0;
                        r_state   <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (i_TX_Done) begin
                        r_state <= S_GAP;
                    end else if (r_tmo == c_TW'(TX_TIMEOUT - 1)) begin
                        // A timeout is a fresh event, so it overrides a same-cycle clear.
                        o_TX_Error <= 1'b1;
                        r_state    <= S_GAP;
                    end else begin
                        r_tmo <= r_tmo + c_TW'(1);
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_buffered_echo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_buffered_echo
// Purpose  : Scoreboard bench for uart_buffered_echo with a simple UART_TX model.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_buffered_echo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int TMO   = 64;
    localparam int FRAME = 10;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_dv = 1'b0;
    logic [DW-1:0] rx_byte = '0;
    logic [1:0]    mode = 2'b00;
    logic          tx_done = 1'b0;
    logic          clear_err = 1'b0;
    logic          model_active = 1'b0;
    logic          force_active = 1'b0;
    logic          done_en = 1'b1;
    wire           tx_active = model_active | force_active;

    logic          o_tx_dv;
    logic [DW-1:0] o_tx_byte;
    logic [DW-1:0] o_display;
    logic [CW-1:0] o_count;
    logic          o_empty, o_full, o_overflow, o_tx_error;

    uart_buffered_echo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TX_TIMEOUT(TMO)) dut (
        .i_Clk          (clk),
        .i_Reset        (rst_n),
        .i_RX_DV        (rx_dv),
        .i_RX_Byte      (rx_byte),
        .i_Mode         (mode),
        .i_TX_Active    (tx_active),
        .i_TX_Done      (tx_done),
        .i_Clear_Err    (clear_err),
        .o_TX_DV        (o_tx_dv),
        .o_TX_Byte      (o_tx_byte),
        .o_Display_Byte (o_display),
        .o_Count        (o_count),
        .o_Empty        (o_empty),
        .o_Full         (o_full),
        .o_Overflow     (o_overflow),
        .o_TX_Error     (o_tx_error)
    );

    always #5 clk = ~clk;

    int            cyc = 0;
    int            tests = 0;
    int            fails = 0;
    int            push_cyc = 0;
    int            launch_cyc = 0;
    int            launch_count = 0;
    int            err_cyc = 0;
    logic [DW-1:0] exp_q [$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every launch must match the head of the expected queue.
    initial forever begin
        @(negedge clk);
        if (rst_n && o_tx_dv) begin
            launch_cyc = cyc;
            launch_count++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_launch: got 0x%0h expected none (cycle %0d)", o_tx_byte, cyc);
            end else begin
                check("tx_byte", 32'(o_tx_byte), 32'(exp_q.pop_front()));
            end
        end
    end

    // Minimal UART_TX: busy for FRAME cycles, then a done strobe if enabled.
    initial forever begin
        @(negedge clk);
        if (rst_n && o_tx_dv) begin
            model_active = 1'b1;
            repeat (FRAME) @(negedge clk);
            if (done_en) begin
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end
            model_active = 1'b0;
        end
    end

    task automatic drive_rx(input logic [7:0] b, input logic [1:0] m);
        @(posedge clk);
        #1;
        rx_dv    = 1'b1;
        rx_byte  = b;
        mode     = m;
        push_cyc = cyc;
    endtask

    task automatic idle_rx();
        @(posedge clk);
        #1;
        rx_dv = 1'b0;
    endtask

    task automatic wait_launch(input int prev);
        int n;
        n = 0;
        while (launch_count == prev && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (launch_count == prev) begin
            tests++;
            fails++;
            $display("FAIL launch_timeout: got no launch expected one within 500 cycles");
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !o_empty) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drained", 32'(exp_q.size()), 32'd0);
        repeat (20) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1;
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
        @(negedge clk);
    endtask

    logic [7:0] t2_in  [8] = '{8'h61, 8'h5A, 8'h7B, 8'h00, 8'h5A, 8'h61, 8'h00, 8'hA5};
    logic [1:0] t2_md  [8] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
    logic [7:0] t2_exp [8] = '{8'h41, 8'h5A, 8'h7B, 8'h00, 8'h7A, 8'h61, 8'hFF, 8'h5A};

    initial begin
        int prev;
        repeat (3) @(negedge clk);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_empty", 32'(o_empty), 32'd1);
        check("rst_full", 32'(o_full), 32'd0);
        check("rst_tx_dv", 32'(o_tx_dv), 32'd0);
        check("rst_tx_byte", 32'(o_tx_byte), 32'd0);
        check("rst_display", 32'(o_display), 32'd0);
        check("rst_flags", 32'({o_overflow, o_tx_error}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: latency n -> n+2, single-cycle strobe
        prev = launch_count;
        exp_q.push_back(8'h41);
        drive_rx(8'h41, 2'b00);
        idle_rx();
        wait_launch(prev);
        check("latency", 32'(launch_cyc - push_cyc), 32'd2);
        check("display", 32'(o_display), 32'h41);
        @(negedge clk);
        check("tx_dv_one_cycle", 32'(o_tx_dv), 32'd0);
        wait_drain();
        check("count_back_to_0", 32'(o_count), 32'd0);

        // 2: transforms
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(t2_exp[i]);
            drive_rx(t2_in[i], t2_md[i]);
            idle_rx();
        end
        check("display_raw", 32'(o_display), 32'hA5);
        wait_drain();

        // 3: overflow; 0x00 leaves at launch so only 0x11 finds the FIFO full
        done_en = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i < 17) exp_q.push_back(8'(i));
            drive_rx(8'(i), 2'b00);
        end
        idle_rx();
        @(negedge clk);
        check("ovf_full", 32'(o_full), 32'd1);
        check("ovf_count", 32'(o_count), 32'd16);
        check("ovf_flag", 32'(o_overflow), 32'd1);
        check("ovf_display", 32'(o_display), 32'h11);
        done_en = 1'b1;
        wait_drain();
        check("ovf_tx_err_after_timeout", 32'(o_tx_error), 32'd1);
        pulse_clear();
        check("clear_flags", 32'({o_overflow, o_tx_error}), 32'd0);

        // 4: push coinciding with pop while full
        force_active = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'hA0 + 8'(i));
            drive_rx(8'hA0 + 8'(i), 2'b00);
        end
        exp_q.push_back(8'hB0);
        drive_rx(8'hB0, 2'b00);
        force_active = 1'b0;
        idle_rx();
        @(negedge clk);
        check("pushpop_count", 32'(o_count), 32'd16);
        check("pushpop_full", 32'(o_full), 32'd1);
        check("pushpop_no_ovf", 32'(o_overflow), 32'd0);
        wait_drain();

        // 5: timeout timing
        done_en = 1'b0;
        prev = launch_count;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h66);
        drive_rx(8'h55, 2'b00);
        drive_rx(8'h66, 2'b00);
        idle_rx();
        wait_launch(prev);
        begin
            int first;
            int n;
            first = launch_cyc;
            n = 0;
            while (!o_tx_error && n < 500) begin
                @(negedge clk);
                n++;
            end
            err_cyc = cyc;
            check("timeout_cycles", 32'(err_cyc - first), 32'(TMO));
        end
        done_en = 1'b1;
        prev = launch_count;
        wait_launch(prev);
        check("relaunch_gap", 32'(launch_cyc - err_cyc), 32'd2);
        pulse_clear();
        check("clear_tx_err", 32'(o_tx_error), 32'd0);
        wait_drain();

        // 6: asynchronous reset mid-WAIT_DONE
        done_en = 1'b0;
        prev = launch_count;
        exp_q.push_back(8'h31);
        for (int i = 0; i < 6; i++) drive_rx(8'h31 + 8'(i), 2'b00);
        idle_rx();
        wait_launch(prev);
        repeat (5) @(negedge clk);
        check("queued_before_reset", 32'(o_count), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(o_count), 32'd0);
        check("arst_empty", 32'(o_empty), 32'd1);
        check("arst_tx_dv", 32'(o_tx_dv), 32'd0);
        check("arst_flags", 32'({o_overflow, o_tx_error, o_full}), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        done_en = 1'b1;
        repeat (30) @(negedge clk);
        check("no_launch_after_reset", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
